// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - switch debounce, mode/speed decode and step/load sequencer for the LED pattern datapath
module led_seq_ctrl #(
  parameter int DB_CYC = 50_000,
  parameter int PER0   = 999_999,
  parameter int PER1   = 1_499_999,
  parameter int PER2   = 2_499_999,
  parameter int PER3   = 4_999_999
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [3:0] sw,
  output logic       step,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       load
);

  localparam int DBW = $clog2(DB_CYC + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

  localparam logic [22:0] P0 = 23'(PER0);
  localparam logic [22:0] P1 = 23'(PER1);
  localparam logic [22:0] P2 = 23'(PER2);
  localparam logic [22:0] P3 = 23'(PER3);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  logic [3:0]     sync1, sync2, db;
  logic [DBW-1:0] db_cnt [4];
  logic [1:0]     state;
  logic [22:0]    cnt;
  logic [22:0]    per_sel;
  logic [1:0]     mode_dec;
  logic           mode_chg, spd_chg, change;
  logic           load_pend;

  // Each bit flips only after DB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    mode_dec = 2'b10;
    if (db[0])      mode_dec = 2'b00;
    else if (db[1]) mode_dec = 2'b01;
  end

  always_comb begin
    per_sel = P0;
    case (speed)
      2'b00:   per_sel = P0;
      2'b01:   per_sel = P1;
      2'b10:   per_sel = P2;
      default: per_sel = P3;
    endcase
  end

  assign mode_chg = (mode_dec != mode);
  assign spd_chg  = (db[3:2] != speed);
  assign change   = mode_chg | spd_chg;

  // step and load are registered pulses; a change always beats a terminal count.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      step      <= 1'b0;
      load      <= 1'b0;
      mode      <= 2'b10;
      speed     <= 2'b00;
      load_pend <= 1'b0;
    end else begin
      mode  <= mode_dec;
      speed <= db[3:2];
      step  <= 1'b0;
      load  <= 1'b0;
      case (state)
        ST_INIT: begin
          cnt   <= '0;
          load  <= 1'b1;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (change) begin
            cnt       <= '0;
            load_pend <= mode_chg;
            state     <= ST_RELOAD;
          end else if (cnt == per_sel) begin
            cnt  <= '0;
            step <= 1'b1;
          end else begin
            cnt <= cnt + 23'd1;
          end
        end
        ST_RELOAD: begin
          cnt  <= '0;
          load <= load_pend;
          if (change) load_pend <= mode_chg;
          else        state     <= ST_RUN;
        end
        default: begin
          cnt   <= '0;
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl
module tb_led_seq_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       step;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       load;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] mode;
    logic [1:0] speed;
    int         loads;
    int         period;
  } vec_t;

  vec_t vt [7];

  led_seq_ctrl #(
    .DB_CYC(4), .PER0(9), .PER1(19), .PER2(29), .PER3(39)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .sw    (sw),
    .step  (step),
    .mode  (mode),
    .speed (speed),
    .load  (load)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Returns the number of cycles until step is seen; n==bound means timeout.
  task automatic wait_step(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!step && n < bound);
  endtask

  task automatic run_count(input int cycles, output int loads, output int steps);
    loads = 0;
    steps = 0;
    repeat (cycles) begin
      @(negedge clk_in);
      if (load) loads++;
      if (step) steps++;
    end
  endtask

  initial begin
    int n, loads, steps, extra;
    int step_log [22];
    int load_log [22];

    vt[0] = '{4'b0001, 2'b00, 2'b00, 1, 10};
    vt[1] = '{4'b0011, 2'b00, 2'b00, 0, 10};
    vt[2] = '{4'b0010, 2'b01, 2'b00, 1, 10};
    vt[3] = '{4'b0110, 2'b01, 2'b01, 0, 20};
    vt[4] = '{4'b1010, 2'b01, 2'b10, 0, 30};
    vt[5] = '{4'b1100, 2'b10, 2'b11, 1, 40};
    vt[6] = '{4'b0000, 2'b10, 2'b00, 0, 10};

    rst_n = 1'b0;
    sw    = 4'b0000;
    repeat (3) @(negedge clk_in);
    check("rst_step", int'(step), 0);
    check("rst_load", int'(load), 0);
    check("rst_mode", int'(mode), 2);
    check("rst_speed", int'(speed), 0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("init_load", int'(load), 1);
    check("init_mode", int'(mode), 2);
    @(negedge clk_in);
    check("init_load_one_cycle", int'(load), 0);
    wait_step(100, n);
    check("first_step_after_load", n + 1, 10);
    wait_step(100, n);
    check("period_after_reset", n, 10);

    // 3-cycle sw1 glitch must be ignored
    sw = 4'b0010;
    repeat (3) @(negedge clk_in);
    sw = 4'b0000;
    run_count(30, loads, steps);
    check("glitch3_loads", loads, 0);
    check("glitch3_mode", int'(mode), 2);
    check("glitch3_steps", steps, 3);

    // 4-cycle pulse is exactly long enough: mode goes 01 and back to 10
    sw = 4'b0010;
    repeat (4) @(negedge clk_in);
    sw = 4'b0000;
    run_count(30, loads, steps);
    check("pulse4_loads", loads, 2);
    check("pulse4_mode", int'(mode), 2);

    foreach (vt[i]) begin
      sw = vt[i].sw;
      run_count(12, loads, steps);
      check($sformatf("vec%0d_loads", i), loads, vt[i].loads);
      check($sformatf("vec%0d_mode", i), int'(mode), int'(vt[i].mode));
      check($sformatf("vec%0d_speed", i), int'(speed), int'(vt[i].speed));
      wait_step(100, n);
      check($sformatf("vec%0d_step_seen", i), int'(n < 100), 1);
      wait_step(100, n);
      check($sformatf("vec%0d_period", i), n, vt[i].period);
    end

    // mode change debounces onto the terminal-count cycle
    wait_step(100, n);
    check("coinc_sync", int'(n < 100), 1);
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk_in);
      step_log[i] = int'(step);
      load_log[i] = int'(load);
      if (i == 3) sw = 4'b0001;
    end
    steps = 0;
    loads = 0;
    for (int i = 1; i <= 20; i++) steps += step_log[i];
    for (int i = 1; i <= 21; i++) loads += load_log[i];
    check("coinc_no_step", steps, 0);
    check("coinc_load_cycle", load_log[11], 1);
    check("coinc_load_count", loads, 1);
    check("coinc_next_step", step_log[21], 1);
    check("coinc_mode", int'(mode), 0);

    // async reset mid-count
    sw = 4'b1101;
    run_count(15, loads, extra);
    check("pre_rst_speed", int'(speed), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_step", int'(step), 0);
    check("arst_load", int'(load), 0);
    check("arst_mode", int'(mode), 2);
    check("arst_speed", int'(speed), 0);
    sw = 4'b0000;
    repeat (3) @(negedge clk_in);
    check("arst_hold_mode", int'(mode), 2);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("arst_release_load", int'(load), 1);
    wait_step(100, n);
    check("arst_first_step", n, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYC, default 50_000, giving the debounce hold time in clk_in cycles (10 ms at 5 MHz).
REQ-002 The block SHALL have parameter PER0, default 999_999, giving the step period minus 1 for speed 2'b00.
REQ-003 The block SHALL have parameter PER1, default 1_499_999, giving the step period minus 1 for speed 2'b01.
REQ-004 The block SHALL have parameter PER2, default 2_499_999, giving the step period minus 1 for speed 2'b10.
REQ-005 The block SHALL have parameter PER3, default 4_999_999, giving the step period minus 1 for speed 2'b11.
REQ-006 The block SHALL have port clk_in, input, 1 bit: the single clock, 5 MHz nominal.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port sw, input, 4 bits: raw asynchronous switches; [1:0] select the mode, [3:2] select the speed.
REQ-009 The block SHALL have port step, output, 1 bit: a one-cycle pulse that advances the LED pattern datapath.
REQ-010 The block SHALL have port mode, output, 2 bits: pattern select; 00 = right shift, 01 = toggle sweep, 10 = left shift.
REQ-011 The block SHALL have port speed, output, 2 bits: the debounced sw[3:2].
REQ-012 The block SHALL have port load, output, 1 bit: a one-cycle pulse that reinitialises the datapath (LED = 4'b0001, toggle mask = 4'b1000).

Function
REQ-013 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized bit SHALL have its own debounce counter, which SHALL restart on any mismatch with the current debounced value.
REQ-015 A debounced bit SHALL take the new value after DB_CYC consecutive mismatching cycles; a glitch shorter than DB_CYC SHALL leave it unchanged.
REQ-016 Mode decode from the debounced bits SHALL be: db[0]=1 gives 00; db[0]=0 and db[1]=1 gives 01; otherwise 10 (sw0 has priority).
REQ-017 speed SHALL equal debounced sw[3:2]; mode and speed outputs SHALL be registered.
REQ-018 The FSM SHALL have states INIT, RUN and RELOAD.
REQ-019 INIT SHALL be entered on reset, SHALL assert load for one cycle, SHALL clear the period counter, and SHALL go to RUN.
REQ-020 In RUN, a 23-bit period counter SHALL increment each cycle.
REQ-021 In RUN, when the counter equals PERx for the current speed, step SHALL pulse for one cycle and the counter SHALL return to 0; the step period is PERx+1 cycles.
REQ-022 A change of the decoded mode or of speed, detected against the previously registered value, SHALL move the FSM from RUN to RELOAD.
REQ-023 RELOAD SHALL clear the counter, SHALL assert load for one cycle only if the mode changed (a speed-only change gives no load), and SHALL return to RUN.
REQ-024 If a change and a terminal count coincide, the change SHALL win: no step pulse and the counter cleared.
REQ-025 step and load SHALL never be asserted in the same cycle; step SHALL be 0 in INIT and in RELOAD.
REQ-026 A change arriving while in RELOAD SHALL be captured and SHALL cause one further RELOAD cycle.
REQ-027 The counter SHALL never exceed PER3; counter width 23 bits, with PERx < 2^23 required.

Reset
REQ-028 While rst_n=0 the outputs SHALL be: step=0, load=0, mode=2'b10, speed=2'b00.
REQ-029 While rst_n=0 the internal state SHALL be: synchronizers=0, debounced=0, debounce counters=0, period counter=0, state=INIT.
REQ-030 Reset assertion mid-operation SHALL force these values immediately, independent of clk_in.
REQ-031 The first rising edge of clk_in after rst_n deasserts SHALL produce load=1.

Verification (DB_CYC=4, PER0=9, PER1=19, PER2=29, PER3=39)
REQ-032 Reset release with sw=0000 -> load pulse on the first edge, mode=10, then step every 10 cycles.
REQ-033 sw0 held high -> after 2+4 cycles mode=00 and a single load pulse; step resumes 10 cycles after the load.
REQ-034 sw1 pulse of 3 cycles (shorter than DB_CYC) -> mode stays 10, no load, step cadence unbroken.
REQ-035 sw[3:2]=11 applied -> after debounce, no load, counter cleared, next step 40 cycles later, then every 40 cycles.
REQ-036 Mode change timed to debounce on the terminal-count cycle -> no step that cycle, load=1 in RELOAD, next step 10 cycles later.
REQ-037 rst_n pulsed low mid-count -> outputs return to reset values asynchronously; load pulses on the first edge after release.
